clk_en_gen: RTL and testbench

CLK_EN_GEN -- requirements
Module: clk_en_gen

---
 rtl/clk_en_gen.sv | 124 ++++++++++++
 tb/tb_clk_en_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// Fractional clock-enable generator: each channel emits cen at an average rate of num/den
// of refclk, plus cenb at the half-period point, with a shared configuration lock detector.

module clk_en_lane #(
  parameter int ACC_W = 24
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] num_i,
  input  logic [ACC_W-1:0] den_i,
  output logic             chg_o,
  output logic             cen_o,
  output logic             cenb_o
);
  logic [ACC_W-1:0] num_q, den_q, acc_q, acc_d;
  logic             cen_q, cen_d, cenb_q, cenb_d;
  logic [ACC_W:0]   sum, den_ext, acc_ext, half;

  assign chg_o = (num_i != num_q) || (den_i != den_q);

  // Extra bit keeps acc+num exact when both sit near 2^ACC_W.
  assign sum     = {1'b0, acc_q} + {1'b0, num_q};
  assign den_ext = {1'b0, den_q};
  assign acc_ext = {1'b0, acc_q};
  assign half    = {1'b0, den_q >> 1};

  always_comb begin
    acc_d  = acc_q;
    cen_d  = 1'b0;
    cenb_d = 1'b0;
    if (chg_o) begin
      acc_d = '0;
    end else if (!enable) begin
      acc_d = acc_q;
    end else if (den_q == '0) begin
      acc_d = '0;
    end else if (num_q >= den_q) begin
      acc_d = '0;
      cen_d = 1'b1;
    end else if (sum >= den_ext) begin
      // sum-den < den, so the low ACC_W bits carry the full result.
      acc_d = sum[ACC_W-1:0] - den_q;
      cen_d = 1'b1;
    end else begin
      acc_d  = sum[ACC_W-1:0];
      cenb_d = (acc_ext < half) && (sum >= half);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      num_q  <= '0;
      den_q  <= '0;
      acc_q  <= '0;
      cen_q  <= 1'b0;
      cenb_q <= 1'b0;
    end else begin
      num_q  <= num_i;
      den_q  <= den_i;
      acc_q  <= acc_d;
      cen_q  <= cen_d;
      cenb_q <= cenb_d;
    end
  end

  assign cen_o  = cen_q;
  assign cenb_o = cenb_q;
endmodule

module clk_en_gen #(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 24,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                      refclk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS*ACC_W-1:0] num,
  input  logic [CHANNELS*ACC_W-1:0] den,
  output logic [CHANNELS-1:0]       cen,
  output logic [CHANNELS-1:0]       cenb,
  output logic                      locked
);
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_CYCLES);

  logic [CHANNELS-1:0][ACC_W-1:0] num_v, den_v;
  logic [CHANNELS-1:0]            chg;
  logic [7:0]                     lock_cnt_q, lock_cnt_d;

  assign num_v = num;
  assign den_v = den;

  clk_en_lane #(.ACC_W(ACC_W)) u_lane [CHANNELS-1:0] (
    .refclk (refclk),
    .rst_n  (rst_n),
    .enable (enable),
    .num_i  (num_v),
    .den_i  (den_v),
    .chg_o  (chg),
    .cen_o  (cen),
    .cenb_o (cenb)
  );

  // Any channel reconfiguring, or the block being paused, restarts the stability count.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if ((|chg) || !enable) begin
      lock_cnt_d = '0;
    end else if (lock_cnt_q != LOCK_MAX) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked = (lock_cnt_q == LOCK_MAX);
endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: per-cycle compare against a step-count model plus
// hand-computed pulse counts and lock timings.

module tb_clk_en_gen;
  localparam int CH = 2;
  localparam int AW = 24;
  localparam int LC = 16;

  logic               refclk;
  logic               rst_n;
  logic               enable;
  logic [CH*AW-1:0]   num, den;
  logic [CH-1:0]      cen, cenb;
  logic               locked;

  int checks = 0;
  int errors = 0;

  clk_en_gen #(.CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(LC)) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .enable (enable),
    .num    (num),
    .den    (den),
    .cen    (cen),
    .cenb   (cenb),
    .locked (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: after n enabled steps from a cleared accumulator, acc = (n*num) mod den,
  // so pulses follow directly from that closed form.
  longint        m_cfg_num [CH];
  longint        m_cfg_den [CH];
  longint        m_steps   [CH];
  logic [CH-1:0] m_cen  = '0;
  logic [CH-1:0] m_cenb = '0;
  int            m_stable = 0;
  longint        mn, md, ma, ms;
  bit            any_chg;

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        m_cfg_num[k] = 0;
        m_cfg_den[k] = 0;
        m_steps[k]   = 0;
      end
      m_cen    = '0;
      m_cenb   = '0;
      m_stable = 0;
    end else begin
      any_chg = 1'b0;
      for (int k = 0; k < CH; k++) begin
        mn = longint'(num[k*AW +: AW]);
        md = longint'(den[k*AW +: AW]);
        if (mn != m_cfg_num[k] || md != m_cfg_den[k]) begin
          any_chg    = 1'b1;
          m_steps[k] = 0;
          m_cen[k]   = 1'b0;
          m_cenb[k]  = 1'b0;
        end else if (!enable || md == 0) begin
          m_cen[k]  = 1'b0;
          m_cenb[k] = 1'b0;
        end else if (mn >= md) begin
          m_cen[k]  = 1'b1;
          m_cenb[k] = 1'b0;
        end else begin
          ma = (m_steps[k] * mn) % md;
          ms = ma + mn;
          m_cen[k]  = (ms >= md);
          m_cenb[k] = (ms < md) && (ma < md / 2) && (ms >= md / 2);
          m_steps[k]++;
        end
        m_cfg_num[k] = mn;
        m_cfg_den[k] = md;
      end
      if (any_chg || !enable) m_stable = 0;
      else if (m_stable < LC) m_stable++;
    end
  end

  always @(negedge refclk) begin
    check("cen", longint'(cen), longint'(m_cen));
    check("cenb", longint'(cenb), longint'(m_cenb));
    check("locked", longint'(locked), longint'(m_stable == LC));
  end

  task automatic tick();
    @(negedge refclk);
  endtask

  task automatic set_ch(input int k, input logic [AW-1:0] n, input logic [AW-1:0] d);
    num[k*AW +: AW] = n;
    den[k*AW +: AW] = d;
  endtask

  int c0, cb0, c1;

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    num    = '0;
    den    = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    check("rst_cen", longint'(cen), 0);
    check("rst_cenb", longint'(cenb), 0);
    check("rst_locked", longint'(locked), 0);

    // ch0 1/4, ch1 3/8, released from reset
    set_ch(0, 24'd1, 24'd4);
    set_ch(1, 24'd3, 24'd8);
    enable = 1'b1;
    rst_n  = 1'b1;
    tick();
    check("first_cfg_edge_cen", longint'(cen), 0);
    c0 = 0; cb0 = 0; c1 = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      c0  += int'(cen[0]);
      cb0 += int'(cenb[0]);
      c1  += int'(cen[1]);
      if (i == 14) check("lock_not_yet", longint'(locked), 0);
    end
    check("lock_after_release", longint'(locked), 1);
    check("ch0_cen_count_16", c0, 4);
    check("ch0_cenb_count_16", cb0, 4);
    check("ch1_cen_count_16", c1, 6);

    // ch0 num 1->2 while locked
    set_ch(0, 24'd2, 24'd4);
    tick();
    check("chg_unlock", longint'(locked), 0);
    check("chg_no_cen0", longint'(cen[0]), 0);
    check("chg_no_cenb0", longint'(cenb[0]), 0);
    repeat (LC - 1) tick();
    check("relock_not_yet", longint'(locked), 0);
    tick();
    check("relock", longint'(locked), 1);

    // den=0 disables ch0, then num=den=5 pulses every cycle
    set_ch(0, 24'd2, 24'd0);
    c0 = 0; cb0 = 0;
    repeat (10) begin
      tick();
      c0  += int'(cen[0]);
      cb0 += int'(cenb[0]);
    end
    check("den0_cen", c0, 0);
    check("den0_cenb", cb0, 0);
    set_ch(0, 24'd5, 24'd5);
    tick();
    check("full_rate_chg_edge", longint'(cen[0]), 0);
    c0 = 0; cb0 = 0;
    repeat (8) begin
      tick();
      c0  += int'(cen[0]);
      cb0 += int'(cenb[0]);
    end
    check("full_rate_cen", c0, 8);
    check("full_rate_cenb", cb0, 0);

    // config change on ch1 coincident with enable falling
    set_ch(1, 24'd5, 24'd8);
    enable = 1'b0;
    tick();
    check("dis_chg_cen", longint'(cen), 0);
    check("dis_chg_locked", longint'(locked), 0);
    repeat (3) tick();
    check("dis_hold_cen", longint'(cen), 0);
    enable = 1'b1;
    repeat (LC + 2) tick();
    check("locked_before_rst", longint'(locked), 1);

    // reset pulse mid-stream
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cen", longint'(cen), 0);
    check("async_rst_cenb", longint'(cenb), 0);
    check("async_rst_locked", longint'(locked), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (LC) tick();
    check("rst_relock_not_yet", longint'(locked), 0);
    tick();
    check("rst_relock", longint'(locked), 1);

    // long-window rate check, ch1 near the top of the accumulator range
    set_ch(0, 24'd12288, 24'd15625);
    set_ch(1, 24'hFFFFFE, 24'hFFFFFF);
    tick();
    c0 = 0; c1 = 0;
    repeat (15625) begin
      tick();
      c0 += int'(cen[0]);
      c1 += int'(cen[1]);
    end
    check("rate_12288_15625", c0, 12288);
    check("rate_near_full", c1, 15624);

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
endmodule
